// File: rtl/calc_display_sequencer.sv
// calc_display_sequencer
//   Sequences a 4-bit add/subtract calculation from operand capture to a
//   held two-digit BCD result. The result is time-multiplexed onto one BCD
//   bus for a seven-segment decoder.
//
//   Flow:   IDLE -> LOAD -> COMPUTE -> CONVERT (x5) -> DONE -> IDLE
//   CONVERT turns the 5-bit magnitude into BCD with shift-add-3, one bit per
//   cycle.
//
// Parameters:
//   SCAN_DIV  clk cycles per scan phase. The phase toggles when the counter
//             reaches SCAN_DIV, so one phase lasts SCAN_DIV+1 cycles.
//   CNT_W     width of the scan counter.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   start    in   single-cycle request, sampled only in IDLE
//   a, b     in   4-bit unsigned operands
//   oper     in   1 = add (a+b), 0 = subtract (a-b)
//   busy     out  high while an operation is in flight (LOAD..DONE)
//   done     out  one-cycle pulse in DONE
//   neg      out  held result sign
//   tens     out  held BCD tens digit (0..3)
//   units    out  held BCD units digit (0..9)
//   bcd_out  out  scanned digit toward the seven-segment decoder
//   u        out  units digit enable, active high
//   d        out  tens digit enable, active high
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  blanks a leading zero tens digit. In phase 0 with
//                          tens==0 it drives d=0 and bcd_out=4'hF.
module calc_display_sequencer #(
  parameter int SCAN_DIV = 166666,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       oper,
  output logic       busy,
  output logic       done,
  output logic       neg,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [3:0] bcd_out,
  output logic       u,
  output logic       d
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_CONVERT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV);

  logic [2:0]       r_state;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic             r_oper;
  logic             r_neg_i;
  logic [12:0]      r_shift;   // {tens_i[3:0], units_i[3:0], mag[4:0]}
  logic [2:0]       r_bitcnt;
  logic             r_neg;
  logic [3:0]       r_tens;
  logic [3:0]       r_units;
  logic [CNT_W-1:0] r_scan_cnt;
  logic             r_phase;
  logic [3:0]       r_bcd_out;
  logic             r_u;
  logic             r_d;

  logic [4:0]       w_mag;
  logic             w_neg;
  logic [3:0]       w_tens_adj;
  logic [3:0]       w_units_adj;
  logic [12:0]      w_shift_next;

  // Operand arithmetic on the captured operands, 5 bits wide.
  always_comb begin
    w_mag = '0;
    w_neg = 1'b0;
    if (r_oper) begin
      w_mag = {1'b0, r_a} + {1'b0, r_b};
    end else if (r_a >= r_b) begin
      w_mag = {1'b0, r_a} - {1'b0, r_b};
    end else begin
      w_mag = {1'b0, r_b} - {1'b0, r_a};
      w_neg = 1'b1;
    end
  end

  // One shift-add-3 step: nibbles >= 5 get +3, then the whole vector
  // shifts left by one.
  always_comb begin
    w_tens_adj   = (r_shift[12:9] >= 4'd5) ? r_shift[12:9] + 4'd3 : r_shift[12:9];
    w_units_adj  = (r_shift[8:5]  >= 4'd5) ? r_shift[8:5]  + 4'd3 : r_shift[8:5];
    w_shift_next = {w_tens_adj[2:0], w_units_adj, r_shift[4:0], 1'b0};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_oper   <= 1'b0;
      r_neg_i  <= 1'b0;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_neg    <= 1'b0;
      r_tens   <= '0;
      r_units  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_a     <= a;
          r_b     <= b;
          r_oper  <= oper;
          r_state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          r_shift  <= {8'h00, w_mag};
          r_neg_i  <= w_neg;
          r_bitcnt <= 3'd5;
          r_state  <= S_CONVERT;
        end
        S_CONVERT: begin
          r_shift  <= w_shift_next;
          r_bitcnt <= r_bitcnt - 3'd1;
          // The last step loads the held outputs directly from the final
          // shift value, so they are valid in the same cycle as done.
          if (r_bitcnt == 3'd1) begin
            r_tens  <= w_shift_next[12:9];
            r_units <= w_shift_next[8:5];
            r_neg   <= r_neg_i;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Free-running scan counter; the phase selects which digit is shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_phase    <= 1'b0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_phase    <= ~r_phase;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Registered digit mux. The enables are one-hot or both low, never both high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd_out <= '0;
      r_u       <= 1'b0;
      r_d       <= 1'b1;
    end else if (r_phase) begin
      r_bcd_out <= r_units;
      r_u       <= 1'b1;
      r_d       <= 1'b0;
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      if (r_tens == 4'd0) begin
        r_bcd_out <= 4'hF;
        r_u       <= 1'b0;
        r_d       <= 1'b0;
      end else begin
        r_bcd_out <= r_tens;
        r_u       <= 1'b0;
        r_d       <= 1'b1;
      end
`else
      r_bcd_out <= r_tens;
      r_u       <= 1'b0;
      r_d       <= 1'b1;
`endif
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign neg     = r_neg;
  assign tens    = r_tens;
  assign units   = r_units;
  assign bcd_out = r_bcd_out;
  assign u       = r_u;
  assign d       = r_d;

endmodule

// File: tb/tb_calc_display_sequencer.sv
module tb_calc_display_sequencer;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
    logic       neg;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       oper;
  logic       busy;
  logic       done;
  logic       neg;
  logic [3:0] tens;
  logic [3:0] units;
  logic [3:0] bcd_out;
  logic       u;
  logic       d;

  int unsigned n_checks;
  int unsigned n_errors;
  exp_t        sb_q[$];
  logic [3:0]  prev_tens;
  logic [3:0]  prev_units;

  calc_display_sequencer #(
    .SCAN_DIV(3),
    .CNT_W(26)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .oper(oper),
    .busy(busy),
    .done(done),
    .neg(neg),
    .tens(tens),
    .units(units),
    .bcd_out(bcd_out),
    .u(u),
    .d(d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] ia, input logic [3:0] ib, input logic io);
    exp_t e;
    int   m;
    if (io) begin
      m = int'(ia) + int'(ib);
      e.neg = 1'b0;
    end else if (ia >= ib) begin
      m = int'(ia) - int'(ib);
      e.neg = 1'b0;
    end else begin
      m = int'(ib) - int'(ia);
      e.neg = 1'b1;
    end
    e.tens  = 4'(m / 10);
    e.units = 4'(m % 10);
    return e;
  endfunction

  task automatic sb_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_tens"},  32'(tens),  32'(e.tens));
      check_val({tag, "_units"}, 32'(units), 32'(e.units));
      check_val({tag, "_neg"},   32'(neg),   32'(e.neg));
      prev_tens  = e.tens;
      prev_units = e.units;
    end
  endtask

  // One operation. Cycle 1 is the cycle after start is sampled (LOAD); done is
  // expected in cycle 8 with busy high for exactly 8 cycles. With disturb set,
  // start is pulsed and the operands change in cycle 3; both must be ignored.
  task automatic do_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                       input logic io, input bit disturb);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = 0;
    sb_q.push_back(model(ia, ib, io));
    @(negedge clk);
    a = ia; b = ib; oper = io; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int idx = 1; idx <= 20; idx++) begin
      if (disturb && idx == 3) begin
        a = 4'd1; b = 4'd1; start = 1'b1;
      end
      if (disturb && idx == 4) start = 1'b0;
      if (idx == 4) begin
        check_val({tag, "_hold_tens"},  32'(tens),  32'(prev_tens));
        check_val({tag, "_hold_units"}, 32'(units), 32'(prev_units));
      end
      if (busy) bcnt++;
      if (done) begin
        lat = idx;
        sb_compare(tag);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_val({tag, "_latency"}, 32'(lat), 32'd8);
    check_val({tag, "_busy_cycles"}, 32'(bcnt), 32'd8);
    @(negedge clk);
    check_val({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic scan_check(input string tag, input int n, input logic [3:0] et, input logic [3:0] eu);
    logic last_u;
    int   run;
    bit   first;
    first = 1'b1;
    run   = 0;
    repeat (2) @(negedge clk);
    last_u = u;
    for (int k = 0; k < n; k++) begin
      check_val({tag, "_excl"}, 32'(u & d), 32'd0);
      if (u) begin
        check_val({tag, "_ph1"}, {27'd0, bcd_out, d}, {27'd0, eu, 1'b0});
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        if (et == 4'd0) check_val({tag, "_ph0"}, {27'd0, bcd_out, d}, {27'd0, 4'hF, 1'b0});
        else            check_val({tag, "_ph0"}, {27'd0, bcd_out, d}, {27'd0, et, 1'b1});
`else
        check_val({tag, "_ph0"}, {27'd0, bcd_out, d}, {27'd0, et, 1'b1});
`endif
      end
      if (u != last_u) begin
        if (!first) check_val({tag, "_period"}, 32'(run), 32'd4);
        first = 1'b0;
        run   = 1;
      end else begin
        run++;
      end
      last_u = u;
      @(negedge clk);
    end
    check_val({tag, "_toggled"}, 32'(first), 32'd0);
  endtask

  initial begin
    int dn1;
    int dn2;
    int ndone;
    n_checks   = 0;
    n_errors   = 0;
    prev_tens  = '0;
    prev_units = '0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; oper = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_val("rst_digits", {24'd0, tens, units}, 32'd0);
    check_val("rst_neg", 32'(neg), 32'd0);
    check_val("rst_disp", {26'd0, bcd_out, u, d}, {26'd0, 4'd0, 1'b0, 1'b1});
    rst = 1'b0;

    do_op("add_7_8",    4'd7,  4'd8,  1'b1, 1'b0);
    do_op("sub_9_12",   4'd9,  4'd12, 1'b0, 1'b0);
    do_op("sub_12_9",   4'd12, 4'd9,  1'b0, 1'b0);
    do_op("add_15_15",  4'd15, 4'd15, 1'b1, 1'b0);
    do_op("sub_0_0",    4'd0,  4'd0,  1'b0, 1'b0);
    do_op("add_7_8_dis", 4'd7, 4'd8,  1'b1, 1'b1);
    do_op("sub_3_15",   4'd3,  4'd15, 1'b0, 1'b0);

    // start held high: back-to-back operations, restart from IDLE after DONE
    sb_q.push_back(model(4'd3, 4'd4, 1'b1));
    sb_q.push_back(model(4'd3, 4'd4, 1'b1));
    dn1 = 0; dn2 = 0;
    @(negedge clk);
    a = 4'd3; b = 4'd4; oper = 1'b1; start = 1'b1;
    @(negedge clk);
    for (int idx = 1; idx <= 30; idx++) begin
      if (done) begin
        if (dn1 == 0) dn1 = idx;
        else if (dn2 == 0) dn2 = idx;
        sb_compare("held_start");
      end
      if (idx >= 17) start = 1'b0;
      @(negedge clk);
    end
    check_val("held_done1", 32'(dn1), 32'd8);
    check_val("held_done2", 32'(dn2), 32'd17);

    // reset during the third CONVERT cycle of 1+1 after a 15+15 result
    do_op("add_15_15b", 4'd15, 4'd15, 1'b1, 1'b0);
    @(negedge clk);
    a = 4'd1; b = 4'd1; oper = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_val("mid_rst_digits", {24'd0, tens, units}, 32'd0);
    check_val("mid_rst_neg", 32'(neg), 32'd0);
    check_val("mid_rst_ud", {30'd0, u, d}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    prev_tens  = '0;
    prev_units = '0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_val("mid_rst_no_done", 32'(ndone), 32'd0);

    do_op("add_15_10", 4'd15, 4'd10, 1'b1, 1'b0);
    scan_check("scan25", 17, 4'd2, 4'd5);
    do_op("add_2_3", 4'd2, 4'd3, 1'b1, 1'b0);
    scan_check("scan05", 10, 4'd0, 4'd5);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
